pipe_reg_chain: RTL and testbench

//  Parametrised elastic pipeline register: DEPTH chained WIDTH-bit stages, each

---
 rtl/pipe_stage.sv | 37 +++
 rtl/pipe_reg_chain.sv | 115 +++++++++++
 tb/tb_pipe_reg_chain.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one data+valid register slot of the elastic pipeline
//
// Purpose: holds one WIDTH-bit word and its valid bit. Data is captured only
//          on load and is never cleared except by reset; clear wins over load.
// Ports:
//   clock  in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high
//   load   in   1      capture d and set valid
//   clear  in   1      drop valid (data retained)
//   d      in   WIDTH  word to capture
//   data   out  WIDTH  stored word
//   valid  out  1      stored word is live
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage elastic pipeline register with flush
//
// Purpose: chain of DEPTH pipe_stage slots with a valid/ready handshake on both
//          ends, back-pressure, bubble collapsing, synchronous flush and a
//          registered occupancy count.
// Ports:
//   clock        in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high
//   flush        in   1      synchronous clear of every stage valid bit
//   in_valid     in   1      upstream word present on data_input
//   in_ready     out  1      chain accepts data_input this cycle
//   data_input   in   WIDTH  upstream word
//   out_valid    out  1      last stage holds a live word
//   out_ready    in   1      downstream accepts data_output
//   data_output  out  WIDTH  last stage word
//   occupancy    out  OCC_W  number of live stages
module pipe_reg_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_input,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_output,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] can_load;
  logic [DEPTH-1:0] moves;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic [WIDTH-1:0] stage_d    [DEPTH];
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // Ready ripples from the output end back to the input; a downstream slot
  // that is empty or emptying lets its upstream neighbour advance.
  always_comb begin
    logic down_ok;
    moves    = '0;
    can_load = '0;
    down_ok  = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      moves[i]    = valid[i] && down_ok;
      can_load[i] = !valid[i] || moves[i];
      down_ok     = can_load[i];
    end
  end

  assign in_ready = can_load[0] && !flush;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // A slot loads when its source hands a word over; a slot that hands its word
  // on without receiving a new one empties. Flush beats any load.
  always_comb begin
    load  = '0;
    clear = '0;
    load[0] = in_xfer && !flush;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = moves[i-1] && !flush;
    end
    for (int i = 0; i < DEPTH; i++) begin
      clear[i] = flush || (moves[i] && !load[i]);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_src_in
      assign stage_d[i] = data_input;
    end else begin : g_src_prev
      assign stage_d[i] = stage_data[i-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .load  (load[i]),
      .clear (clear[i]),
      .d     (stage_d[i]),
      .data  (stage_data[i]),
      .valid (valid[i])
    );
  end

  assign out_valid   = valid[DEPTH-1];
  assign data_output = stage_data[DEPTH-1];

  // Tracks popcount(valid) incrementally instead of summing the valid bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  always_ff @(posedge clock) begin
    assert (DEPTH >= 1 && DEPTH <= 16)
      else $error("pipe_reg_chain: DEPTH %0d outside 1..16", DEPTH);
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - randomized and directed bench for pipe_reg_chain (DEPTH 3 and 1)
module tb_pipe_reg_chain;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  data_input;
  logic          out_ready;

  logic          in_ready0, out_valid0;
  logic [W-1:0]  data_out0;
  logic [1:0]    occ0;
  logic          in_ready1, out_valid1;
  logic [W-1:0]  data_out1;
  logic [0:0]    occ1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(3)) dut3 (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready0),
    .data_input  (data_input),
    .out_valid   (out_valid0),
    .out_ready   (out_ready),
    .data_output (data_out0),
    .occupancy   (occ0)
  );

  pipe_reg_chain #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready1),
    .data_input  (data_input),
    .out_valid   (out_valid1),
    .out_ready   (out_ready),
    .data_output (data_out1),
    .occupancy   (occ1)
  );

  // Reference: each chain is an ordered list of words, each with a stage
  // position. Per cycle the head leaves if it sits at the last stage and
  // out_ready is high; every word then advances one stage unless it would
  // collide with the word ahead of it.
  int          mdep [2];
  int          mcnt [2];
  int          mpos [2][16];
  logic [W-1:0] mdat [2][16];
  logic [W-1:0] mlast [2];
  logic        last_inr0;
  logic [W-1:0] nxt;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int m);
    mcnt[m]  = 0;
    mlast[m] = '0;
  endtask

  task automatic model_cycle(input int m, input logic iv, input logic [W-1:0] d,
                             input logic ordy, input logic fl,
                             input logic o_inr, input logic o_outv,
                             input logic [W-1:0] o_data, input int o_occ,
                             output logic inr);
    int   np [16];
    int   n, off, lim, dep, cand;
    logic outv;
    dep  = mdep[m];
    outv = (mcnt[m] > 0) && (mpos[m][0] == dep - 1);
    off  = (outv && ordy) ? 1 : 0;
    n    = mcnt[m] - off;
    for (int k = 0; k < n; k++) begin
      lim   = (k == 0) ? dep - 1 : np[k-1] - 1;
      cand  = mpos[m][k+off] + 1;
      np[k] = (cand < lim) ? cand : lim;
    end
    inr = !fl && !(n > 0 && np[n-1] == 0);
    check_eq($sformatf("d%0d in_ready", dep), {31'd0, o_inr}, {31'd0, inr});
    check_eq($sformatf("d%0d out_valid", dep), {31'd0, o_outv}, {31'd0, outv});
    check_eq($sformatf("d%0d data_output", dep), o_data, mlast[m]);
    check_eq($sformatf("d%0d occupancy", dep), W'(o_occ), W'(mcnt[m]));
    if (fl) begin
      mcnt[m] = 0;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (np[k] == dep - 1 && mpos[m][k+off] != dep - 1) mlast[m] = mdat[m][k+off];
        mdat[m][k] = mdat[m][k+off];
        mpos[m][k] = np[k];
      end
      mcnt[m] = n;
      if (iv && inr) begin
        mpos[m][n] = 0;
        mdat[m][n] = d;
        if (dep == 1) mlast[m] = d;
        mcnt[m] = n + 1;
      end
    end
  endtask

  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    logic r0, r1;
    @(negedge clock);
    in_valid   = iv;
    data_input = d;
    out_ready  = ordy;
    flush      = fl;
    #1;
    model_cycle(0, iv, d, ordy, fl, in_ready0, out_valid0, data_out0, int'(occ0), r0);
    model_cycle(1, iv, d, ordy, fl, in_ready1, out_valid1, data_out1, int'(occ1), r1);
    last_inr0 = r0;
    @(posedge clock);
  endtask

  // Offers the next word of a counting sequence; advances when the DEPTH=3 chain takes it.
  task automatic push(input logic ordy);
    cyc(1'b1, nxt, ordy, 1'b0);
    if (last_inr0) nxt++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, ordy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check_eq("d3 rst out_valid", {31'd0, out_valid0}, 32'd0);
    check_eq("d3 rst data_output", data_out0, 32'd0);
    check_eq("d3 rst occupancy", {30'd0, occ0}, 32'd0);
    check_eq("d1 rst out_valid", {31'd0, out_valid1}, 32'd0);
    check_eq("d1 rst data_output", data_out1, 32'd0);
    check_eq("d1 rst occupancy", {31'd0, occ1}, 32'd0);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset(0);
    model_reset(1);
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    mdep[0] = 3;
    mdep[1] = 1;
    model_reset(0);
    model_reset(1);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; data_input = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check_reset_outputs();
    check_eq("d3 rst in_ready", {31'd0, in_ready0}, 32'd1);
    check_eq("d1 rst in_ready", {31'd0, in_ready1}, 32'd1);
    reset = 1'b0;
    @(posedge clock);

    // stream with downstream always ready
    nxt = 32'hA0;
    repeat (5) push(1'b1);
    idle(5, 1'b1);

    // back-pressure, then release
    nxt = 32'hA0;
    repeat (5) push(1'b0);
    // full pass-through: drain A0 while accepting B0 on the same edge
    cyc(1'b1, 32'hB0, 1'b1, 1'b0);
    idle(6, 1'b1);

    // bubble collapse behind a stalled head
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 1'b0, 1'b0);
    idle(5, 1'b1);

    // flush with two words held and a word offered
    cyc(1'b1, 32'h01, 1'b0, 1'b0);
    cyc(1'b1, 32'h02, 1'b0, 1'b0);
    cyc(1'b1, 32'hCC, 1'b0, 1'b1);
    idle(4, 1'b1);

    // async reset while full, then resume streaming
    nxt = 32'hD0;
    repeat (4) push(1'b0);
    async_reset();
    repeat (5) push(1'b1);
    idle(4, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 65),
          1'($urandom_range(0, 99) < 5));
    end
    idle(5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
